// File: rtl/raptor64_btb.sv
// raptor64_btb: 64-entry direct-mapped branch target buffer for the Raptor64
// fetch stage, indexed by pc[7:2]. Filled from EX on taken branches; a
// hardware sweep invalidates every entry after reset.
// Build option: define RAPTOR64_BTB_TAG_EN to store and compare pc[63:8] tags;
// left undefined, the table is tagless and aliasing PCs share an entry.
//
// state | meaning
// CLEAR | sweep writing valid=0 at clr_idx, lookups and updates suppressed
// RUN   | normal lookup and update
module raptor64_btb (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pc,
  input  logic        predict_taken,
  input  logic        advanceX,
  input  logic        xIsBranch,
  input  logic [63:0] xpc,
  input  logic        takb,
  input  logic [63:0] xtarget,
  output logic        btb_hit,
  output logic [63:0] btb_target,
  output logic        fetch_redirect,
  output logic        busy
);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t      state, state_nx;
  logic [5:0]  clr_idx;
  logic [63:0] valid;
  logic [61:0] tgt_mem [64];
  logic [5:0]  rd_idx;
  logic [5:0]  wr_idx;
  logic        upd;
  logic        tag_ok;

`ifdef RAPTOR64_BTB_TAG_EN
  logic [55:0] tag_mem [64];
  logic        unused_lsb;
  assign unused_lsb = ^{pc[1:0], xtarget[1:0], xpc[1:0]};
`else
  logic        unused_bits;
  assign unused_bits = ^{pc[1:0], pc[63:8], xtarget[1:0], xpc[1:0], xpc[63:8]};
`endif

  assign rd_idx = pc[7:2];
  assign wr_idx = xpc[7:2];
  assign busy   = (state == CLEAR);
  assign upd    = advanceX & xIsBranch & takb & ~busy;

  // State register and sweep pointer; reset restarts the sweep from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= 6'd0;
    end else begin
      state <= state_nx;
      if (state == CLEAR) clr_idx <= clr_idx + 6'd1;
    end
  end

  // Next state: leave CLEAR after the write that clears entry 63.
  always_comb begin
    state_nx = state;
    case (state)
      CLEAR:   if (clr_idx == 6'd63) state_nx = RUN;
      RUN:     state_nx = RUN;
      default: state_nx = CLEAR;
    endcase
  end

  // Valid bits: the sweep clears one entry per cycle, taken branches set theirs.
  always_ff @(posedge clk) begin
    if (!rst && state == CLEAR) valid[clr_idx] <= 1'b0;
    else if (upd)               valid[wr_idx]  <= 1'b1;
  end

  // Target (and tag) payload; written only on an accepted update.
  always_ff @(posedge clk) begin
    if (upd) begin
      tgt_mem[wr_idx] <= xtarget[63:2];
`ifdef RAPTOR64_BTB_TAG_EN
      tag_mem[wr_idx] <= xpc[63:8];
`endif
    end
  end

  // Combinational lookup; the pre-write contents are seen during a write.
  always_comb begin
`ifdef RAPTOR64_BTB_TAG_EN
    tag_ok = (tag_mem[rd_idx] == pc[63:8]);
`else
    tag_ok = 1'b1;
`endif
    btb_hit        = valid[rd_idx] & tag_ok & ~busy;
    btb_target     = btb_hit ? {tgt_mem[rd_idx], 2'b00} : 64'd0;
    fetch_redirect = btb_hit & predict_taken;
  end

endmodule

// File: doc/raptor64_btb.md
# raptor64_btb

Branch target buffer for the Raptor64 fetch stage. It pairs with the two-bit branch history predictor: the predictor answers "taken?" for the IF-stage PC, and this block answers "where to?". Together they drive the fetch redirect. The table is filled from the EX stage when a branch resolves taken. After reset, a hardware sweep invalidates every entry.

## Interface
Parameters:
- none; geometry is fixed at 64 entries, direct-mapped, indexed by pc[7:2].

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-high
- pc  in  64  IF-stage program counter (lookup address)
- predict_taken  in  1  IF-stage taken prediction from the branch history block
- advanceX  in  1  EX stage advances this cycle
- xIsBranch  in  1  instruction in EX is a conditional branch, BTRI/BTRR or TRAPcc/TRAPcci
- xpc  in  64  EX-stage program counter of the resolving branch
- takb  in  1  EX-stage branch resolved taken
- xtarget  in  64  EX-stage resolved target address
- btb_hit  out  1  lookup for pc found a valid (and, if enabled, tag-matching) entry
- btb_target  out  64  stored target for pc; {entry[61:0],2'b00}
- fetch_redirect  out  1  btb_hit & predict_taken & ~busy
- busy  out  1  invalidation sweep in progress

## Operation
- Storage per entry: valid (1), target[63:2] (62), and optionally tag pc[63:8] (56).
- Lookup is combinational (asynchronous-read table): index = pc[7:2].
  - btb_hit = valid[idx] (& tag match when enabled) & ~busy.
  - btb_target = stored target, or 0 when btb_hit=0.
- Update condition: advanceX & xIsBranch & takb & ~busy.
  - Write at index xpc[7:2]: valid=1, target=xtarget[63:2], tag=xpc[63:8].
  - Overwrites any previous occupant of that index.
- Branches resolved not-taken leave the table untouched. The history counters handle the direction.
- xtarget[1:0] is ignored; targets are word-aligned.
- State machine, two states:
  - CLEAR: write valid=0 at sweep index clr_idx (6 bits), then clr_idx+1. When clr_idx==63, go to RUN after that write.
  - RUN: normal lookup and update. Stays in RUN until rst.
- rst=1 in any state, including mid-sweep: next state CLEAR, clr_idx=0, so the sweep restarts from entry 0.
- busy = (state==CLEAR).

## Timing
- Reset values:
  - state=CLEAR, clr_idx=0, busy=1.
  - btb_hit=0, btb_target=0 and fetch_redirect=0 while busy.
- Sweep length:
  - busy stays high for exactly 64 cycles after the first clock edge with rst=0.
  - busy drops after the edge that clears entry 63.
- Lookup latency 0: outputs follow pc in the same cycle.
- Update latency 1: a write at edge N is visible to lookups from cycle N+1.
- Same-index read during write: the read returns the pre-write contents in that cycle.
- Updates requested while busy are dropped, not queued.
- advanceX=0: no write, whatever xIsBranch and takb are.
- Write and lookup to different indices in the same cycle are independent.

## Configuration
- RAPTOR64_BTB_TAG_EN defined:
  - The 56-bit tag is stored and compared.
  - btb_hit requires valid & (tag==pc[63:8]).
- RAPTOR64_BTB_TAG_EN undefined:
  - Tagless table; btb_hit = valid[idx] & ~busy.
  - PCs aliasing in bits [7:2] share the entry, which saves 64×56 bits.

## Test plan
- Reset sweep: pulse rst 1 cycle, then hold pc=0x100 -> busy=1 for 64 cycles and btb_hit=0 throughout; at cycle 65 busy=0, btb_hit=0.
- Fill and hit:
  - After sweep: advanceX=1, xIsBranch=1, takb=1, xpc=0x1004, xtarget=0x2000.
  - Next cycle pc=0x1004 -> btb_hit=1, btb_target=0x2000.
  - predict_taken=1 -> fetch_redirect=1; predict_taken=0 -> fetch_redirect=0.
- Non-updates:
  - takb=0 with xpc=0x3008 -> no hit at pc=0x3008.
  - advanceX=0 with takb=1 -> no write.
  - Both leave an existing entry unchanged.
- Aliasing:
  - Write xpc=0x1004, then look up pc=0x1104.
  - With TAG_EN: btb_hit=0.
  - Without TAG_EN: btb_hit=1, target 0x2000.
  - A second write at xpc=0x1104, xtarget=0x4000 replaces the entry; 0x1004 misses (TAG_EN) or returns 0x4000.
- Reset mid-sweep and mid-operation:
  - Assert rst at sweep cycle 30 -> busy stays 1; sweep restarts and busy falls 64 cycles after rst deasserts.
  - Entries written before that reset all miss afterwards.
  - An update presented while busy=1 is lost.
